// File: rtl/ff_bank.sv
// ---------------------------------------------------------------------------
// ff_bank
//
// Bank of WIDTH flip-flops whose next-state function (D, T, JK or SR) is
// selected at runtime and advanced by a debounced push-button.  Sits between
// board switches/buttons and the LEDs.
//
// Parameters
//   WIDTH     number of flip-flop channels (>= 1)
//   DEBOUNCE  consecutive cycles the synchronised step level must differ from
//             the accepted level before the new level is accepted (>= 1)
//   CNT_W     width of step_count (>= 1)
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   reset       synchronous active-high reset
//   step        raw asynchronous push-button, one update per accepted press
//   mode        next-state function: 00 D, 01 T, 10 JK, 11 SR
//   a           per-channel D / T / J / S input
//   b           per-channel K / R input (ignored in D and T modes)
//   q           flip-flop state
//   q_n         combinational complement of q
//   step_count  number of bank updates since reset, modulo 2^CNT_W
//   updated     one-cycle pulse following every bank update
//   sr_fault    sticky flag: an SR update saw S=R=1 on some channel
// ---------------------------------------------------------------------------
module ff_bank #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [CNT_W-1:0] step_count,
    output logic             updated,
    output logic             sr_fault
);

    // Debounce counter only needs to hold 0..DEBOUNCE-1.
    localparam int            DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE - 1);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    // Synchroniser stages: *_meta_r may go metastable, *_s_r is the clean copy.
    logic             step_meta_r;
    logic             step_s_r;
    logic [1:0]       mode_meta_r;
    logic [1:0]       mode_s_r;
    logic [WIDTH-1:0] a_meta_r;
    logic [WIDTH-1:0] a_s_r;
    logic [WIDTH-1:0] b_meta_r;
    logic [WIDTH-1:0] b_s_r;

    // Debouncer state.
    logic             db_level_r;
    logic [DB_W-1:0]  db_cnt_r;

    // Bank state.
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] step_count_r;
    logic             updated_r;
    logic             sr_fault_r;

    // Combinational helpers.
    logic             db_differs_s;
    logic             db_expired_s;
    logic             update_s;
    logic [WIDTH-1:0] next_q_s;
    logic             conflict_s;

    // JK next state: J sets, K clears, both toggle, neither holds.
    function automatic logic [WIDTH-1:0] jk_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] j,
        input logic [WIDTH-1:0] k
    );
        jk_next = (j & ~cur) | (~k & cur);
    endfunction

    // SR next state: S sets, R clears; S=R=1 holds the bit (flagged separately).
    function automatic logic [WIDTH-1:0] sr_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] r
    );
        sr_next = (cur | (s & ~r)) & ~(r & ~s);
    endfunction

    // Two-flop synchronisers for every asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_meta_r <= 1'b0;
            step_s_r    <= 1'b0;
            mode_meta_r <= 2'b00;
            mode_s_r    <= 2'b00;
            a_meta_r    <= '0;
            a_s_r       <= '0;
            b_meta_r    <= '0;
            b_s_r       <= '0;
        end else begin
            step_meta_r <= step;
            step_s_r    <= step_meta_r;
            mode_meta_r <= mode;
            mode_s_r    <= mode_meta_r;
            a_meta_r    <= a;
            a_s_r       <= a_meta_r;
            b_meta_r    <= b;
            b_s_r       <= b_meta_r;
        end
    end

    // A press is accepted on the cycle the counter has already seen
    // DEBOUNCE-1 differing cycles and the level still differs.
    assign db_differs_s = (step_s_r != db_level_r);
    assign db_expired_s = (db_cnt_r == DB_MAX);
    assign update_s     = db_differs_s & db_expired_s & step_s_r;

    // Debouncer: count consecutive cycles where the synchronised level differs.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_level_r <= 1'b0;
            db_cnt_r   <= '0;
        end else if (!db_differs_s) begin
            db_cnt_r   <= '0;
        end else if (db_expired_s) begin
            db_level_r <= step_s_r;
            db_cnt_r   <= '0;
        end else begin
            db_cnt_r   <= db_cnt_r + DB_W'(1);
        end
    end

    // Next-state selection for the whole bank from the synchronised mode.
    always_comb begin
        next_q_s   = q_r;
        conflict_s = 1'b0;
        case (mode_s_r)
            MODE_D:  next_q_s = a_s_r;
            MODE_T:  next_q_s = q_r ^ a_s_r;
            MODE_JK: next_q_s = jk_next(q_r, a_s_r, b_s_r);
            MODE_SR: begin
                next_q_s   = sr_next(q_r, a_s_r, b_s_r);
                conflict_s = |(a_s_r & b_s_r);
            end
            default: next_q_s = q_r;
        endcase
    end

    // Bank update, update counter, one-cycle pulse and sticky SR fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r          <= '0;
            step_count_r <= '0;
            updated_r    <= 1'b0;
            sr_fault_r   <= 1'b0;
        end else begin
            updated_r <= update_s;
            if (update_s) begin
                q_r          <= next_q_s;
                step_count_r <= step_count_r + CNT_W'(1);
                if (conflict_s) begin
                    sr_fault_r <= 1'b1;
                end else begin
                    sr_fault_r <= sr_fault_r;
                end
            end else begin
                q_r          <= q_r;
                step_count_r <= step_count_r;
                sr_fault_r   <= sr_fault_r;
            end
        end
    end

    assign q          = q_r;
    assign q_n        = ~q_r;
    assign step_count = step_count_r;
    assign updated    = updated_r;
    assign sr_fault   = sr_fault_r;

endmodule
